if_fetch_ctrl: RTL and testbench



---
 rtl/if_fetch_ctrl_if.sv | 22 ++
 rtl/if_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and the memory.
// The memory accepts every request; the response arrives at least one cycle later.
interface if_fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, an output slot for IF/ID, delay-slot redirects
// and flush. Define IF_RANGE_CHECK_EN to turn bad fetch addresses into error nops.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  input  logic                  flush_i,
  input  logic [31:0]           flush_pc_i,
  if_fetch_ctrl_if.master       mem,
  output logic [31:0]           instr_o,
  output logic [31:0]           pc_o,
  output logic                  instr_valid_o,
  output logic                  fetch_err_o
);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  localparam logic [32:0] PcLimit = {1'b0, RESET_PC} + ({1'b0, 32'(IMEM_WORDS)} << 2);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        consume, can_issue, range_bad, addr_err;

  assign consume   = valid_q && !stall_i;
  assign can_issue = !valid_q || !stall_i;
  assign range_bad = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < RESET_PC) ||
                     ({1'b0, fetch_pc_q} >= PcLimit);

`ifdef IF_RANGE_CHECK_EN
  assign addr_err = range_bad;
`else
  logic unused_range_bad;
  assign unused_range_bad = range_bad;
  assign addr_err         = 1'b0;
`endif

  assign mem.req  = (state_q == StReq) && can_issue && !flush_i && !reset && !addr_err;
  assign mem.addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    err_d      = err_q;

    // A consumed slot empties unless something below refills it this cycle.
    if (consume) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          valid_d    = 1'b0;
          err_d      = 1'b0;
        end else if (can_issue) begin
          if (addr_err) begin
            instr_d    = '0;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            err_d      = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            // The address issuing now is the delay slot; the redirect takes effect after it.
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = (redirect_i && consume) ? redirect_pc_i : fetch_pc_q + 32'd4;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          valid_d    = 1'b0;
          err_d      = 1'b0;
          state_d    = mem.rvalid ? StReq : StDrop;
        end else if (mem.rvalid) begin
          instr_d = mem.rdata;
          pc_d    = req_pc_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          valid_d    = 1'b0;
          err_d      = 1'b0;
        end
        if (mem.rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: cycle vector table plus flush and range-check sequences,
// with a queue of requested PCs checked against consumed slots.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RstPc = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, redir = 1'b0, flush = 1'b0;
  logic [31:0] rpc = '0, fpc = '0;
  logic [31:0] instr, pc;
  logic        valid, err;

  if_fetch_ctrl_if mem();

  if_fetch_ctrl #(
    .RESET_PC  (RstPc),
    .IMEM_WORDS(4096)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .flush_i      (flush),
    .flush_pc_i   (fpc),
    .mem          (mem),
    .instr_o      (instr),
    .pc_o         (pc),
    .instr_valid_o(valid),
    .fetch_err_o  (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] raddr = '0;
  logic [31:0] sb_q[$];
  bit          sb_en = 1'b0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Variable-latency memory; reset drops any outstanding transaction.
  always @(posedge clk) begin
    if (reset) begin
      cnt        <= 0;
      mem.rvalid <= 1'b0;
      mem.rdata  <= '0;
    end else begin
      mem.rvalid <= 1'b0;
      if (mem.req) begin
        if (lat == 1) begin
          mem.rvalid <= 1'b1;
          mem.rdata  <= mdata(mem.addr);
        end else begin
          cnt   <= lat - 1;
          raddr <= mem.addr;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          mem.rvalid <= 1'b1;
          mem.rdata  <= mdata(raddr);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: one outstanding request at most, and consumed slots match requested PCs in order.
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset && mem.req) chk("one_outstanding", 32'(cnt), 32'd0);
    if (sb_en && !reset && valid && !stall) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow_pc", pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, mdata(e));
      end
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic f,
                     input logic [31:0] fp);
    @(negedge clk);
    reset = 1'b0;
    stall = s;
    redir = r;
    rpc   = rp;
    flush = f;
    fpc   = fp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    redir = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mem.req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc, RstPc);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // stall redir rpc | req addr valid pc
    tbl[0]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3004, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3004, 1'b1, 32'h3000};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3008, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3008, 1'b1, 32'h3004};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h300C, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h300C, 1'b1, 32'h3008};
    tbl[7]  = '{1'b1, 1'b1, 32'h6000, 1'b0, 32'h300C, 1'b1, 32'h3008};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h300C, 1'b1, 32'h3008};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h300C, 1'b1, 32'h3008};
    tbl[10] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3010, 1'b1, 32'h300C};
    tbl[12] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3014, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h3100, 1'b1, 32'h3014, 1'b1, 32'h3010};
    tbl[14] = '{1'b0, 1'b1, 32'h5000, 1'b0, 32'h3100, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3100, 1'b1, 32'h3014};
    tbl[16] = '{1'b0, 1'b1, 32'h5000, 1'b0, 32'h3104, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3104, 1'b1, 32'h3100};
    tbl[18] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3108, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3108, 1'b1, 32'h3104};

    // Streaming, stall hold, ignored redirects and a delay-slot branch with 1-cycle memory.
    lat = 1;
    do_reset();
    sb_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(tbl[k].stall, tbl[k].redir, tbl[k].rpc, 1'b0, 32'h0);
      if (tbl[k].req) sb_q.push_back(tbl[k].addr);
      chk($sformatf("v%0d_req", k), 32'(mem.req), 32'(tbl[k].req));
      chk($sformatf("v%0d_addr", k), mem.addr, tbl[k].addr);
      chk($sformatf("v%0d_valid", k), 32'(valid), 32'(tbl[k].valid));
      chk($sformatf("v%0d_err", k), 32'(err), 32'd0);
      if (tbl[k].valid) begin
        chk($sformatf("v%0d_pc", k), pc, tbl[k].pc);
        chk($sformatf("v%0d_instr", k), instr, mdata(tbl[k].pc));
      end
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_en = 1'b0;
    chk("sb_left", 32'(sb_q.size()), 32'd1);
    sb_q.delete();

    // Flush while waiting on a 3-cycle memory: stale response must be dropped.
    lat = 3;
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h3020);
    chk("fl0_req", 32'(mem.req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl1_req", 32'(mem.req), 32'd1);
    chk("fl1_addr", mem.addr, 32'h3020);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4180);
    chk("fl2_req", 32'(mem.req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl3_req", 32'(mem.req), 32'd0);
    chk("fl3_valid", 32'(valid), 32'd0);
    chk("fl3_addr", mem.addr, 32'h4180);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl4_stale_rvalid", 32'(mem.rvalid), 32'd1);
    chk("fl4_req", 32'(mem.req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl5_valid", 32'(valid), 32'd0);
    chk("fl5_req", 32'(mem.req), 32'd1);
    chk("fl5_addr", mem.addr, 32'h4180);
    repeat (3) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("fl_wait_valid", 32'(valid), 32'd0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl9_valid", 32'(valid), 32'd1);
    chk("fl9_pc", pc, 32'h4180);
    chk("fl9_instr", instr, mdata(32'h4180));
    chk("fl9_req", 32'(mem.req), 32'd1);
    chk("fl9_addr", mem.addr, 32'h4184);
    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Flush in the same cycle as the response: data discarded, restart next cycle.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4180);
    chk("fr_rvalid", 32'(mem.rvalid), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fr_valid", 32'(valid), 32'd0);
    chk("fr_req", 32'(mem.req), 32'd1);
    chk("fr_addr", mem.addr, 32'h4180);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

`ifdef IF_RANGE_CHECK_EN
    // Out-of-range and misaligned fetches become error nops with no memory request.
    lat = 1;
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h7000, 1'b0, 32'h0);
    chk("rc2_pc", pc, 32'h3000);
    chk("rc2_addr", mem.addr, 32'h3004);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rc4_pc", pc, 32'h3004);
    chk("rc4_addr", mem.addr, 32'h7000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rc5_req", 32'(mem.req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rc6_valid", 32'(valid), 32'd1);
    chk("rc6_pc", pc, 32'h7000);
    chk("rc6_instr", instr, 32'd0);
    chk("rc6_err", 32'(err), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h3002);
    chk("rc7_req", 32'(mem.req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rc8_valid", 32'(valid), 32'd0);
    chk("rc8_err", 32'(err), 32'd0);
    chk("rc8_req", 32'(mem.req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rc9_valid", 32'(valid), 32'd1);
    chk("rc9_pc", pc, 32'h3002);
    chk("rc9_instr", instr, 32'd0);
    chk("rc9_err", 32'(err), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
